// File: rtl/gpio_in_pkg.sv
// Shared register map and edge-mode encodings for the GPIO input capture block.
package gpio_in_pkg;

  typedef enum logic [1:0] {
    ADDR_DATA = 2'd0,
    ADDR_RAW  = 2'd1,
    ADDR_MASK = 2'd2,
    ADDR_EDGE = 2'd3
  } reg_addr_e;

  localparam int EDGE_RISING  = 0;
  localparam int EDGE_FALLING = 1;
  localparam int EDGE_ANY     = 2;

  function automatic logic edge_hit(input int mode, input logic prev, input logic cur);
    case (mode)
      EDGE_RISING:  return ~prev & cur;
      EDGE_FALLING: return prev & ~cur;
      default:      return prev ^ cur;
    endcase
  endfunction

endpackage

// File: rtl/gpio_debounce_bit.sv
// One input channel: 2-flop synchronizer followed by a stable-count debouncer.
module gpio_debounce_bit #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter bit INIT_LEVEL      = 1'b1
) (
  input  logic clk,
  input  logic srst,
  input  logic din,
  output logic sync,
  output logic deb
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

  logic             meta_reg;
  logic             sync_reg;
  logic             deb_reg;
  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (srst) begin
      meta_reg <= INIT_LEVEL;
      sync_reg <= INIT_LEVEL;
      deb_reg  <= INIT_LEVEL;
      cnt_reg  <= '0;
    end else begin
      meta_reg <= din;
      sync_reg <= meta_reg;
      // Accept the new level only on the edge after the count has reached the limit.
      if (sync_reg != deb_reg) begin
        if (cnt_reg == CNT_MAX) begin
          deb_reg <= sync_reg;
          cnt_reg <= '0;
        end else begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end else begin
        cnt_reg <= '0;
      end
    end
  end

  assign sync = sync_reg;
  assign deb  = deb_reg;

endmodule

// File: rtl/gpio_in_capture.sv
// Debounced GPIO input port with edge capture, interrupt mask and Avalon-MM slave.
module gpio_in_capture
  import gpio_in_pkg::*;
#(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int EDGE_MODE       = 2,
  parameter bit INIT_LEVEL      = 1'b1
) (
  input  logic             clk_clk,
  input  logic             reset_reset,
  input  logic [WIDTH-1:0] gpio_in,
  input  logic [1:0]       avs_address,
  input  logic             avs_read,
  input  logic             avs_write,
  input  logic [31:0]      avs_writedata,
  output logic [31:0]      avs_readdata,
  output logic             irq
);

  logic [WIDTH-1:0] raw;
  logic [WIDTH-1:0] deb;
  logic [WIDTH-1:0] deb_d_reg;
  logic [WIDTH-1:0] mask_reg;
  logic [WIDTH-1:0] edge_reg;
  logic [WIDTH-1:0] edge_set;
  logic [WIDTH-1:0] edge_clr;
  logic [WIDTH-1:0] edge_next;
  logic [31:0]      rd_word;
  logic [31:0]      readdata_reg;
  logic             irq_reg;
  logic             unused_wdata;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_ch
      gpio_debounce_bit #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .INIT_LEVEL     (INIT_LEVEL)
      ) u_bit (
        .clk (clk_clk),
        .srst(reset_reset),
        .din (gpio_in[gi]),
        .sync(raw[gi]),
        .deb (deb[gi])
      );
      assign edge_set[gi] = edge_hit(EDGE_MODE, deb_d_reg[gi], deb[gi]);
    end
  endgenerate

  assign edge_clr     = (avs_write && avs_address == ADDR_EDGE) ? avs_writedata[WIDTH-1:0] : '0;
  // Set is OR-ed after the clear so a coincident capture survives a W1C.
  assign edge_next    = (edge_reg & ~edge_clr) | edge_set;
  assign unused_wdata = ^avs_writedata;

  always_comb begin
    rd_word = '0;
    case (reg_addr_e'(avs_address))
      ADDR_DATA: rd_word[WIDTH-1:0] = deb;
      ADDR_RAW:  rd_word[WIDTH-1:0] = raw;
      ADDR_MASK: rd_word[WIDTH-1:0] = mask_reg;
      ADDR_EDGE: rd_word[WIDTH-1:0] = edge_reg;
      default:   rd_word = '0;
    endcase
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      deb_d_reg    <= {WIDTH{INIT_LEVEL}};
      mask_reg     <= '0;
      edge_reg     <= '0;
      readdata_reg <= '0;
      irq_reg      <= 1'b0;
    end else begin
      deb_d_reg <= deb;
      edge_reg  <= edge_next;
      irq_reg   <= |(edge_reg & mask_reg);
      if (avs_write && avs_address == ADDR_MASK) begin
        mask_reg <= avs_writedata[WIDTH-1:0];
      end
      if (avs_read) begin
        readdata_reg <= rd_word;
      end
    end
  end

  assign avs_readdata = readdata_reg;
  assign irq          = irq_reg;

endmodule

// File: tb/tb_gpio_in_capture.sv
// Scoreboard bench: stimulus queues expected read data and irq; a monitor checks each read response.
module tb_gpio_in_capture;

  localparam int WIDTH = 8;
  localparam int DEB   = 4;

  logic             clk = 1'b0;
  logic             reset_reset;
  logic [WIDTH-1:0] gpio_in;
  logic [1:0]       avs_address;
  logic             avs_read;
  logic             avs_write;
  logic [31:0]      avs_writedata;
  logic [31:0]      avs_readdata;
  logic             irq;

  typedef struct {
    string       name;
    logic [31:0] data;
    logic        irq;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   n_checks = 0;
  int   n_fail = 0;
  int   probe_cnt = 0;
  int   probe_seen = 0;
  bit   pend = 1'b0;
  bit   done = 1'b0;
  bit   finished = 1'b0;

  gpio_in_capture #(
    .WIDTH          (WIDTH),
    .DEBOUNCE_CYCLES(DEB),
    .EDGE_MODE      (2),
    .INIT_LEVEL     (1'b1)
  ) dut (
    .clk_clk      (clk),
    .reset_reset  (reset_reset),
    .gpio_in      (gpio_in),
    .avs_address  (avs_address),
    .avs_read     (avs_read),
    .avs_write    (avs_write),
    .avs_writedata(avs_writedata),
    .avs_readdata (avs_readdata),
    .irq          (irq)
  );

  always #5 clk = ~clk;

  always @(posedge clk) pend <= avs_read;

  // Monitor: pops one expectation per read response (or direct probe).
  initial begin
    forever begin
      @(negedge clk);
      if (pend || probe_cnt != probe_seen) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL scoreboard_empty: response readdata=0x%08h with no expectation", avs_readdata);
        end else begin
          cur = sb.pop_front();
          n_checks += 2;
          if (avs_readdata !== cur.data) begin
            n_fail++;
            $display("FAIL %s: readdata=0x%08h expected 0x%08h", cur.name, avs_readdata, cur.data);
          end
          if (irq !== cur.irq) begin
            n_fail++;
            $display("FAIL %s_irq: irq=%0b expected %0b", cur.name, irq, cur.irq);
          end
          $display("%t %s: readdata=0x%08h irq=%0b", $time, cur.name, avs_readdata, irq);
        end
        if (probe_cnt != probe_seen) probe_seen++;
      end
      if (done && !finished) begin
        n_checks++;
        if (sb.size() != 0) begin
          n_fail++;
          $display("FAIL scoreboard_leftover: %0d pending expected 0", sb.size());
        end
        finished = 1'b1;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_read(input logic [1:0] a, input logic [31:0] d, input logic i, input string nm);
    avs_address = a;
    avs_read    = 1'b1;
    sb.push_back('{name: nm, data: d, irq: i});
    tick(1);
    avs_read = 1'b0;
  endtask

  task automatic do_write(input logic [1:0] a, input logic [31:0] d);
    avs_address   = a;
    avs_writedata = d;
    avs_write     = 1'b1;
    tick(1);
    avs_write = 1'b0;
  endtask

  task automatic do_rw(input logic [1:0] a, input logic [31:0] wd, input logic [31:0] d,
                       input logic i, input string nm);
    avs_address   = a;
    avs_writedata = wd;
    avs_write     = 1'b1;
    avs_read      = 1'b1;
    sb.push_back('{name: nm, data: d, irq: i});
    tick(1);
    avs_write = 1'b0;
    avs_read  = 1'b0;
  endtask

  task automatic probe(input logic [31:0] d, input logic i, input string nm);
    sb.push_back('{name: nm, data: d, irq: i});
    probe_cnt++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_reset   = 1'b1;
    gpio_in       = 8'hFF;
    avs_address   = 2'd0;
    avs_read      = 1'b0;
    avs_write     = 1'b0;
    avs_writedata = 32'h0;
    tick(3);
    probe(32'h0, 1'b0, "reset_outputs");
    tick(1);
    reset_reset = 1'b0;

    // Reset release with all inputs high.
    do_read(2'd0, 32'hFF, 1'b0, "rst_data");
    do_read(2'd1, 32'hFF, 1'b0, "rst_raw");
    do_read(2'd2, 32'h00, 1'b0, "rst_mask");
    for (int k = 0; k < 20; k++) do_read(2'd3, 32'h00, 1'b0, "rst_edge");

    // bit0 falls: DATA changes exactly 7 cycles after the first sampling edge.
    gpio_in = 8'hFE;
    for (int k = 0; k < 7; k++) do_read(2'd0, 32'hFF, 1'b0, "fall0_data_old");
    do_read(2'd0, 32'hFE, 1'b0, "fall0_data_new");
    do_read(2'd3, 32'h01, 1'b0, "fall0_edge");
    do_read(2'd1, 32'hFE, 1'b0, "fall0_raw");

    // 3-cycle glitch on bit3 is rejected.
    gpio_in = 8'hF6;
    tick(3);
    gpio_in = 8'hFE;
    tick(10);
    do_read(2'd0, 32'hFE, 1'b0, "glitch3_data");
    do_read(2'd3, 32'h01, 1'b0, "glitch3_edge");

    // Read-only registers ignore writes; mask/irq path and W1C.
    do_write(2'd0, 32'h00);
    do_write(2'd1, 32'h00);
    do_read(2'd0, 32'hFE, 1'b0, "ro_data");
    do_write(2'd2, 32'h01);
    do_read(2'd2, 32'h01, 1'b1, "mask_irq_on");
    do_rw(2'd3, 32'h01, 32'h01, 1'b1, "edge_rw_prewrite");
    do_read(2'd3, 32'h00, 1'b0, "edge_cleared_irq_off");

    // W1C on bit2 coinciding with its capture: set wins.
    do_write(2'd2, 32'h04);
    gpio_in = 8'hFA;
    for (int k = 0; k < 7; k++) do_read(2'd0, 32'hFE, 1'b0, "fall2_data");
    do_rw(2'd3, 32'h04, 32'h00, 1'b0, "collide_prewrite");
    do_read(2'd3, 32'h04, 1'b1, "collide_edge_kept");
    do_read(2'd3, 32'h04, 1'b1, "collide_edge_hold");
    do_write(2'd3, 32'h04);
    do_read(2'd3, 32'h00, 1'b0, "bit2_cleared");

    // Rising edge on bit0 is captured in any-edge mode.
    do_write(2'd2, 32'h00);
    gpio_in = 8'hFB;
    tick(12);
    do_read(2'd0, 32'hFB, 1'b0, "rise0_data");
    do_read(2'd3, 32'h01, 1'b0, "rise0_edge");
    do_write(2'd3, 32'h01);
    do_read(2'd3, 32'h00, 1'b0, "rise0_cleared");

    // Reset in the middle of a bit5 debounce discards it.
    gpio_in = 8'hFF;
    tick(12);
    do_read(2'd0, 32'hFF, 1'b0, "rise2_data");
    do_write(2'd2, 32'h04);
    do_read(2'd3, 32'h04, 1'b1, "pre_reset_edge");
    gpio_in = 8'hDF;
    tick(4);
    reset_reset = 1'b1;
    gpio_in     = 8'hFF;
    tick(1);
    probe(32'h0, 1'b0, "midreset_outputs");
    tick(1);
    reset_reset = 1'b0;
    do_read(2'd0, 32'hFF, 1'b0, "post_reset_data");
    do_read(2'd3, 32'h00, 1'b0, "post_reset_edge");
    do_read(2'd2, 32'h00, 1'b0, "post_reset_mask");
    tick(12);
    do_read(2'd0, 32'hFF, 1'b0, "post_reset_data_late");
    do_read(2'd3, 32'h00, 1'b0, "post_reset_edge_late");

    tick(3);
    done = 1'b1;
    wait (finished);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
